// File: rtl/collision_sequencer_pkg.sv
// Shared game definitions: sprite size, lane geometry, coordinate widths and
// the scan FSM encoding. Also used by the car-movement and game-state blocks.
package collision_sequencer_pkg;

    // Sprite edge in pixels (frog and car share the same tile)
    localparam int TILE_SIZE_PX      = 32;

    // Coordinate widths; SUM_W leaves one spare bit so position+tile never wraps
    localparam int X_W               = 10;
    localparam int Y_W               = 9;
    localparam int SUM_W             = 11;

    // Lane index width covers up to 8 lanes
    localparam int LANE_IDX_W        = 3;
    localparam int DEFAULT_NUM_LANES = 6;

    // Lane top-Y values, lane k at bits [9k+8:9k]; lane 0 is the bottom road row
    localparam logic [Y_W*DEFAULT_NUM_LANES-1:0] LANE_Y_DEFAULT =
        {9'd320, 9'd288, 9'd256, 9'd192, 9'd160, 9'd128};

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } seq_state_e;

    // One-axis strict overlap of two tiles; touching edges do not count
    function automatic logic overlap_1d(input logic [SUM_W-1:0] a,
                                        input logic [SUM_W-1:0] b,
                                        input int               tile);
        return (a < (b + SUM_W'(tile))) && (b < (a + SUM_W'(tile)));
    endfunction

    // Grace counter width: enough for GRACE_FRAMES, never narrower than one bit
    function automatic int grace_width(input int frames);
        return (frames > 0) ? $clog2(frames + 1) : 1;
    endfunction

endpackage

// File: rtl/collision_sequencer_tile_overlap_check.sv
// Combinational tile-overlap compare of one frog/car pair on a given lane row.
// All arithmetic is widened to SUM_W bits so right/bottom edges never wrap.
module tile_overlap_check
    import collision_sequencer_pkg::*;
#(
    parameter int TILE_SIZE = TILE_SIZE_PX
) (
    input  logic [X_W-1:0] frog_x,
    input  logic [Y_W-1:0] frog_y,
    input  logic [X_W-1:0] car_x,
    input  logic [Y_W-1:0] lane_y,
    output logic           hit
);

    logic [SUM_W-1:0] frog_x_w;
    logic [SUM_W-1:0] car_x_w;
    logic [SUM_W-1:0] frog_y_w;
    logic [SUM_W-1:0] lane_y_w;
    logic             hit_x;
    logic             hit_y;

    assign frog_x_w = SUM_W'(frog_x);
    assign car_x_w  = SUM_W'(car_x);
    assign frog_y_w = SUM_W'(frog_y);
    assign lane_y_w = SUM_W'(lane_y);

    assign hit_x = overlap_1d(frog_x_w, car_x_w, TILE_SIZE);
    assign hit_y = overlap_1d(frog_y_w, lane_y_w, TILE_SIZE);
    assign hit   = hit_x && hit_y;

endmodule

// File: rtl/collision_sequencer.sv
// Per-frame collision scheduler. Snapshots frog and car positions on a frame
// start, walks the lanes one per cycle through a single shared comparator,
// and reports the lowest hit lane subject to a post-hit grace window.
module collision_sequencer
    import collision_sequencer_pkg::*;
#(
    parameter int                                TILE_SIZE    = TILE_SIZE_PX,
    parameter int                                NUM_LANES    = DEFAULT_NUM_LANES,
    parameter logic [Y_W*DEFAULT_NUM_LANES-1:0]  LANE_Y_LIST  = LANE_Y_DEFAULT,
    parameter int                                GRACE_FRAMES = 60
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_Enable,
    input  logic                     i_Frame_Start,
    input  logic [X_W-1:0]           i_Frog_X,
    input  logic [Y_W-1:0]           i_Frog_Y,
    input  logic [X_W*NUM_LANES-1:0] i_Car_X_Bus,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Hit,
    output logic [LANE_IDX_W-1:0]    o_Hit_Lane,
    output logic                     o_Collision_Pulse,
    output logic                     o_Suppressed
);

    localparam int                    GRACE_W    = grace_width(GRACE_FRAMES);
    localparam logic [GRACE_W-1:0]    GRACE_LOAD = GRACE_W'(GRACE_FRAMES);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE  = LANE_IDX_W'(NUM_LANES - 1);

    // FSM state
    seq_state_e state_q, state_d;

    // Snapshot taken at frame start; the scan only ever looks at these
    logic [X_W-1:0]           frog_x_q,  frog_x_d;
    logic [Y_W-1:0]           frog_y_q,  frog_y_d;
    logic [X_W*NUM_LANES-1:0] car_bus_q, car_bus_d;

    // Scan progress and hit accumulator
    logic [LANE_IDX_W-1:0]    lane_q,     lane_d;
    logic                     acc_hit_q,  acc_hit_d;
    logic [LANE_IDX_W-1:0]    hit_lane_q, hit_lane_d;

    // Reported result and grace window
    logic                     hit_q,      hit_d;
    logic [LANE_IDX_W-1:0]    out_lane_q, out_lane_d;
    logic [GRACE_W-1:0]       grace_q,    grace_d;

    // Shared comparator operands, muxed by the current lane index
    logic [X_W-1:0]           car_x_sel;
    logic [Y_W-1:0]           lane_y_sel;
    logic                     lane_hit;

    // Scan-end helpers: the last lane's result is folded in combinationally
    logic                     last_lane;
    logic                     final_hit;
    logic [LANE_IDX_W-1:0]    final_lane;

    assign car_x_sel  = car_bus_q[X_W*int'(lane_q) +: X_W];
    assign lane_y_sel = LANE_Y_LIST[Y_W*int'(lane_q) +: Y_W];

    tile_overlap_check #(
        .TILE_SIZE (TILE_SIZE)
    ) u_overlap (
        .frog_x (frog_x_q),
        .frog_y (frog_y_q),
        .car_x  (car_x_sel),
        .lane_y (lane_y_sel),
        .hit    (lane_hit)
    );

    assign last_lane  = (lane_q == LAST_LANE);
    assign final_hit  = acc_hit_q | lane_hit;
    assign final_lane = acc_hit_q ? hit_lane_q : lane_q;

    // Next-state logic: one cycle per lane, then a single report cycle
    always_comb begin
        // NOTE: assign every output of a combinational block up front so no
        // path leaves it unassigned; a missing default infers a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Frame_Start && i_Enable) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_lane) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any scan in progress without reporting it
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: snapshot on start, accumulate per lane, update result at scan end
    always_comb begin
        frog_x_d   = frog_x_q;
        frog_y_d   = frog_y_q;
        car_bus_d  = car_bus_q;
        lane_d     = lane_q;
        acc_hit_d  = acc_hit_q;
        hit_lane_d = hit_lane_q;
        hit_d      = hit_q;
        out_lane_d = out_lane_q;
        grace_d    = grace_q;

        case (state_q)
            ST_IDLE: begin
                if (i_Frame_Start && i_Enable) begin
                    frog_x_d   = i_Frog_X;
                    frog_y_d   = i_Frog_Y;
                    car_bus_d  = i_Car_X_Bus;
                    lane_d     = '0;
                    acc_hit_d  = 1'b0;
                    hit_lane_d = '0;
                end
            end
            ST_SCAN: begin
                // Only the first (lowest) hit lane is kept
                if (lane_hit && !acc_hit_q) begin
                    hit_lane_d = lane_q;
                end
                acc_hit_d = final_hit;

                if (!last_lane) begin
                    lane_d = lane_q + LANE_IDX_W'(1);
                end else if (final_hit && (grace_q == '0)) begin
                    // Fresh hit: report it and open the grace window
                    hit_d      = 1'b1;
                    out_lane_d = final_lane;
                    grace_d    = GRACE_LOAD;
                end else begin
                    // No hit, or a hit inside the grace window: report clear
                    hit_d      = 1'b0;
                    out_lane_d = '0;
                    if (grace_q != '0) begin
                        grace_d = grace_q - GRACE_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; everything clears on reset, including the grace window
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            frog_x_q   <= '0;
            frog_y_q   <= '0;
            car_bus_q  <= '0;
            lane_q     <= '0;
            acc_hit_q  <= 1'b0;
            hit_lane_q <= '0;
            hit_q      <= 1'b0;
            out_lane_q <= '0;
            grace_q    <= '0;
        end else begin
            frog_x_q   <= frog_x_d;
            frog_y_q   <= frog_y_d;
            car_bus_q  <= car_bus_d;
            lane_q     <= lane_d;
            acc_hit_q  <= acc_hit_d;
            hit_lane_q <= hit_lane_d;
            hit_q      <= hit_d;
            out_lane_q <= out_lane_d;
            grace_q    <= grace_d;
        end
    end

    // Outputs decode directly from flops, so reset forces them low at once
    assign o_Busy            = (state_q != ST_IDLE);
    assign o_Done            = (state_q == ST_REPORT);
    assign o_Hit             = hit_q;
    assign o_Hit_Lane        = out_lane_q;
    assign o_Collision_Pulse = o_Done & hit_q;
    assign o_Suppressed      = (grace_q != '0);

endmodule

// File: tb/tb_collision_sequencer.sv
// Directed bench for collision_sequencer. Two instances share all inputs:
// one with default parameters and one with a three-frame grace window.
module tb_collision_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic [9:0]  frog_x;
    logic [8:0]  frog_y;
    logic [59:0] car_bus;

    logic        busy, done, hit, pulse, supp;
    logic [2:0]  lane;
    logic        g_busy, g_done, g_hit, g_pulse, g_supp;
    logic [2:0]  g_lane;

    int vectors = 0;
    int errors  = 0;

    // Results captured by run_frame at the o_Done cycle
    int          f_done_cyc;
    int          f_n_done;
    logic [11:0] f_busy;
    logic        f_hit, f_pulse, f_supp, fg_hit, fg_supp;
    logic [2:0]  f_lane;

    int          exp_g_hit  [5] = '{1, 0, 0, 0, 1};
    int          exp_g_supp [5] = '{1, 1, 1, 0, 1};

    collision_sequencer dut (
        .i_Clk             (clk),
        .i_Rst_L           (rst_n),
        .i_Enable          (enable),
        .i_Frame_Start     (start),
        .i_Frog_X          (frog_x),
        .i_Frog_Y          (frog_y),
        .i_Car_X_Bus       (car_bus),
        .o_Busy            (busy),
        .o_Done            (done),
        .o_Hit             (hit),
        .o_Hit_Lane        (lane),
        .o_Collision_Pulse (pulse),
        .o_Suppressed      (supp)
    );

    collision_sequencer #(.GRACE_FRAMES(3)) dut_g (
        .i_Clk             (clk),
        .i_Rst_L           (rst_n),
        .i_Enable          (enable),
        .i_Frame_Start     (start),
        .i_Frog_X          (frog_x),
        .i_Frog_Y          (frog_y),
        .i_Car_X_Bus       (car_bus),
        .o_Busy            (g_busy),
        .o_Done            (g_done),
        .o_Hit             (g_hit),
        .o_Hit_Lane        (g_lane),
        .o_Collision_Pulse (g_pulse),
        .o_Suppressed      (g_supp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [59:0] cars(input logic [9:0] c0, input logic [9:0] c1,
                                         input logic [9:0] c2, input logic [9:0] c3,
                                         input logic [9:0] c4, input logic [9:0] c5);
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Start pulse in cycle 0, then observe cycles 1..11
    task automatic run_frame();
        f_done_cyc = 0;
        f_n_done   = 0;
        f_busy     = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            f_busy[c] = busy;
            if (done) begin
                f_n_done++;
                f_done_cyc = c;
                f_hit      = hit;
                f_lane     = lane;
                f_pulse    = pulse;
                f_supp     = supp;
                fg_hit     = g_hit;
                fg_supp    = g_supp;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input logic eh, input logic [2:0] el,
                               input logic es);
        check({tag, "_done_cycle"}, f_done_cyc, 7);
        check({tag, "_done_count"}, f_n_done, 1);
        check({tag, "_hit"}, f_hit, eh);
        check({tag, "_lane"}, f_lane, el);
        check({tag, "_pulse"}, f_pulse, eh);
        check({tag, "_suppressed"}, f_supp, es);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        start   = 1'b0;
        frog_x  = '0;
        frog_y  = '0;
        car_bus = cars(600, 600, 600, 600, 600, 600);
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hit", hit, 0);
        check("reset_lane", lane, 0);
        check("reset_pulse", pulse, 0);
        check("reset_suppressed", supp, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic hit on lane 0
        frog_x = 100; frog_y = 128;
        car_bus = cars(90, 600, 600, 600, 600, 600);
        run_frame();
        check("basic_busy_window", f_busy, 12'h0FE);
        check_frame("basic", 1'b1, 3'd0, 1'b1);
        check("basic_grace_dut_hit", fg_hit, 1);
        check("basic_hit_held", hit, 1);
        check("basic_pulse_cleared", pulse, 0);

        // Edge contact is not a hit; one pixel more is
        apply_reset();
        frog_x = 100; frog_y = 160;
        car_bus = cars(600, 68, 600, 600, 600, 600);
        run_frame();
        check_frame("edge_touch", 1'b0, 3'd0, 1'b0);
        car_bus = cars(600, 69, 600, 600, 600, 600);
        run_frame();
        check_frame("edge_overlap", 1'b1, 3'd1, 1'b1);

        // Right-edge sums must not wrap at 10 bits
        apply_reset();
        frog_x = 0; frog_y = 128;
        car_bus = cars(1010, 600, 600, 600, 600, 600);
        run_frame();
        check_frame("nowrap_far", 1'b0, 3'd0, 1'b0);
        frog_x = 1000;
        run_frame();
        check_frame("nowrap_near", 1'b1, 3'd0, 1'b1);

        // Frog row straddles lanes 1 and 2: lowest lane wins
        apply_reset();
        frog_x = 100; frog_y = 170;
        car_bus = cars(600, 100, 100, 600, 600, 600);
        run_frame();
        check_frame("multi_hit", 1'b1, 3'd1, 1'b1);

        // Hit only on the final lane scanned
        apply_reset();
        frog_x = 100; frog_y = 320;
        car_bus = cars(600, 600, 600, 600, 600, 100);
        run_frame();
        check_frame("last_lane", 1'b1, 3'd5, 1'b1);

        // Persistent overlap for five frames
        apply_reset();
        frog_x = 100; frog_y = 128;
        car_bus = cars(90, 600, 600, 600, 600, 600);
        for (int i = 0; i < 5; i++) begin
            run_frame();
            check($sformatf("grace3_hit_f%0d", i + 1), fg_hit, exp_g_hit[i]);
            check($sformatf("grace3_supp_f%0d", i + 1), fg_supp, exp_g_supp[i]);
            check($sformatf("grace60_hit_f%0d", i + 1), f_hit, (i == 0) ? 1 : 0);
            check($sformatf("grace60_supp_f%0d", i + 1), f_supp, 1);
        end

        // Start during scan ignored; late input changes and enable drop ignored
        apply_reset();
        frog_x = 100; frog_y = 128;
        car_bus = cars(90, 600, 600, 600, 600, 600);
        f_done_cyc = 0;
        f_n_done   = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", busy, 1);
        @(negedge clk);
        car_bus = cars(600, 600, 600, 600, 600, 600);
        enable  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 4; c <= 14; c++) begin
            if (done) begin
                f_n_done++;
                f_done_cyc = c;
                f_hit      = hit;
                f_lane     = lane;
            end
            @(negedge clk);
        end
        check("snapshot_done_cycle", f_done_cyc, 7);
        check("snapshot_done_count", f_n_done, 1);
        check("snapshot_hit", f_hit, 1);
        check("snapshot_lane", f_lane, 0);
        enable = 1'b1;
        run_frame();
        check_frame("post_snapshot", 1'b0, 3'd0, 1'b1);

        // Reset in the middle of a scan
        apply_reset();
        car_bus = cars(90, 600, 600, 600, 600, 600);
        run_frame();
        check_frame("pre_reset", 1'b1, 3'd0, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_hit", hit, 0);
        check("midreset_suppressed", supp, 0);
        f_n_done = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) rst_n = 1'b1;
            if (done) f_n_done++;
            @(negedge clk);
        end
        check("midreset_no_done", f_n_done, 0);
        run_frame();
        check_frame("after_reset", 1'b1, 3'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
